// File: rtl/exp_ro_pkg.sv
// Shared types and defaults for the exposure/readout frame sequencer.
//   state_t       : sequencer FSM states
//   ROW_W_DEFAULT : default width of the row address buses
//   CNT_W_DEFAULT : default width of the frame count / frame limit
package exp_ro_pkg;

  localparam int ROW_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXPOSE   = 3'd1,
    READ     = 3'd2,
    READ_EXP = 3'd3,
    HOLD     = 3'd4
  } state_t;

endpackage

// File: rtl/ro_done_detect.sv
// Readout-side status tracking for the frame sequencer.
//   CLK, rst_n  : clock, asynchronous active-low reset
//   ro_busy_i   : readout engine busy
//   ro_start_i  : sequencer's registered readout start pulse
//   ro_done_o   : one-cycle pulse, one cycle after ro_busy_i falls
//   exp_hold_o  : readout owns the ROWADD bus (busy, or started but not yet busy)
module ro_done_detect
  import exp_ro_pkg::*;
(
  input  logic CLK,
  input  logic rst_n,
  input  logic ro_busy_i,
  input  logic ro_start_i,
  output logic ro_done_o,
  output logic exp_hold_o
);

  logic busy_q;
  logic done_q;
  logic pend_q;
  logic hold_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      busy_q <= ro_busy_i;
      done_q <= busy_q & ~ro_busy_i;
      // Covers the gap between the start pulse and the engine raising busy,
      // so the bus never flips back to the exposure side in between.
      if (ro_start_i) begin
        pend_q <= 1'b1;
      end else if (ro_busy_i) begin
        pend_q <= 1'b0;
      end
      hold_q <= ro_busy_i | pend_q;
    end
  end

  assign ro_done_o  = done_q;
  assign exp_hold_o = hold_q;

endmodule

// File: rtl/exp_ro_sequencer.sv
// Frame-level sequencer between the exposure engine and the readout engine.
// Issues exposure/readout triggers, arbitrates the shared ROWADD bus and
// counts completed frames, in sequential or overlapped mode.
//   CLK, rst_n          : clock, asynchronous active-low reset
//   start, stop         : acquisition start / graceful stop pulses
//   overlap_en          : overlapped mode, sampled at each exposure-complete
//   num_frames          : frames to acquire (0 = free-run until stop)
//   exp_done_i          : exposure complete pulse
//   ro_busy_i           : readout engine busy
//   rowadd_exp_i/ro_i   : row addresses from the two engines
//   exp_trigger_o       : start one exposure (pulse)
//   ro_start_o          : start one readout (pulse)
//   exp_hold_o          : readout owns the bus
//   ROWADD              : registered muxed row address
//   frame_cnt           : completed readouts since the last start (saturating)
//   busy, done, ovr_err : not idle / return-to-idle pulse / sticky overrun
module exp_ro_sequencer
  import exp_ro_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             overlap_en,
  input  logic [CNT_W-1:0] num_frames,
  input  logic             exp_done_i,
  input  logic             ro_busy_i,
  input  logic [ROW_W-1:0] rowadd_exp_i,
  input  logic [ROW_W-1:0] rowadd_ro_i,
  output logic             exp_trigger_o,
  output logic             ro_start_o,
  output logic             exp_hold_o,
  output logic [ROW_W-1:0] ROWADD,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             done,
  output logic             ovr_err
);

  state_t           state_q, state_d;
  logic             exp_trig_q, exp_trig_d;
  logic             ro_start_q, ro_start_d;
  logic             done_q, done_d;
  logic             cnt_inc, ovr_set, acq_clr;
  logic [CNT_W-1:0] frame_cnt_q, exp_issued_q;
  logic             stop_req_q, ovr_err_q;
  logic [ROW_W-1:0] rowadd_q;
  logic             ro_done, exp_hold;
  logic             more, ovl_more;

  ro_done_detect u_ro_done_detect (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .ro_busy_i  (ro_busy_i),
    .ro_start_i (ro_start_q),
    .ro_done_o  (ro_done),
    .exp_hold_o (exp_hold)
  );

  // exp_issued counts the in-flight exposure too, so "more" answers whether
  // another exposure may be launched.
  assign more     = !stop_req_q && (num_frames == '0 || exp_issued_q < num_frames);
  assign ovl_more = overlap_en && more;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      exp_trig_q   <= 1'b0;
      ro_start_q   <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
      exp_issued_q <= '0;
      stop_req_q   <= 1'b0;
      ovr_err_q    <= 1'b0;
      rowadd_q     <= '0;
    end else begin
      state_q    <= state_d;
      exp_trig_q <= exp_trig_d;
      ro_start_q <= ro_start_d;
      done_q     <= done_d;
      rowadd_q   <= exp_hold ? rowadd_ro_i : rowadd_exp_i;

      if (acq_clr) begin
        frame_cnt_q  <= '0;
        exp_issued_q <= CNT_W'(1);   // start always launches the first exposure
        stop_req_q   <= 1'b0;
        ovr_err_q    <= 1'b0;
      end else begin
        if (cnt_inc && frame_cnt_q != '1) begin
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
        if (exp_trig_d && exp_issued_q != '1) begin
          exp_issued_q <= exp_issued_q + CNT_W'(1);
        end
        if (stop && state_q != IDLE) begin
          stop_req_q <= 1'b1;
        end
      end
      if (ovr_set) begin
        ovr_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = EXPOSE;
      EXPOSE:   if (exp_done_i) state_d = ovl_more ? READ_EXP : READ;
      READ:     if (ro_done) state_d = more ? EXPOSE : IDLE;
      READ_EXP: begin
        if (ro_done && exp_done_i) state_d = ovl_more ? READ_EXP : READ;
        else if (ro_done)          state_d = EXPOSE;
        else if (exp_done_i)       state_d = HOLD;
      end
      HOLD:     if (ro_done) state_d = ovl_more ? READ_EXP : READ;
      default:  state_d = IDLE;
    endcase
  end

  // A finished exposure that cannot be read out yet parks in HOLD; any further
  // exposure result arriving with nowhere to go is flagged and dropped.
  always_comb begin
    exp_trig_d = 1'b0;
    ro_start_d = 1'b0;
    done_d     = 1'b0;
    cnt_inc    = 1'b0;
    ovr_set    = 1'b0;
    acq_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ovr_set = exp_done_i;
        if (start) begin
          acq_clr    = 1'b1;
          exp_trig_d = 1'b1;
        end
      end
      EXPOSE: begin
        if (exp_done_i) begin
          ro_start_d = 1'b1;
          exp_trig_d = ovl_more;
        end
      end
      READ: begin
        ovr_set = exp_done_i;
        if (ro_done) begin
          cnt_inc    = 1'b1;
          exp_trig_d = more;
          done_d     = !more;
        end
      end
      READ_EXP: begin
        if (ro_done) begin
          cnt_inc = 1'b1;
          if (exp_done_i) begin
            ro_start_d = 1'b1;
            exp_trig_d = ovl_more;
          end
        end
      end
      HOLD: begin
        ovr_set = exp_done_i;
        if (ro_done) begin
          cnt_inc    = 1'b1;
          ro_start_d = 1'b1;
          exp_trig_d = ovl_more;
        end
      end
      default: ;
    endcase
  end

  assign exp_trigger_o = exp_trig_q;
  assign ro_start_o    = ro_start_q;
  assign exp_hold_o    = exp_hold;
  assign ROWADD        = rowadd_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ovr_err       = ovr_err_q;

endmodule

// File: tb/tb_exp_ro_sequencer.sv
module tb_exp_ro_sequencer;
  import exp_ro_pkg::*;

  localparam int ROW_W = 8;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             overlap_en = 1'b0;
  logic [CNT_W-1:0] num_frames = '0;
  logic             exp_done_i = 1'b0;
  logic             ro_busy_i = 1'b0;
  logic [ROW_W-1:0] rowadd_exp_i = '0;
  logic [ROW_W-1:0] rowadd_ro_i = '0;
  logic             exp_trigger_o, ro_start_o, exp_hold_o, busy, done, ovr_err;
  logic [ROW_W-1:0] ROWADD;
  logic [CNT_W-1:0] frame_cnt;

  exp_ro_sequencer #(.ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stop(stop), .overlap_en(overlap_en),
    .num_frames(num_frames), .exp_done_i(exp_done_i), .ro_busy_i(ro_busy_i),
    .rowadd_exp_i(rowadd_exp_i), .rowadd_ro_i(rowadd_ro_i),
    .exp_trigger_o(exp_trigger_o), .ro_start_o(ro_start_o), .exp_hold_o(exp_hold_o),
    .ROWADD(ROWADD), .frame_cnt(frame_cnt), .busy(busy), .done(done), .ovr_err(ovr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int frames;
    int trig;
    int rost;
    bit ovr;
  } run_t;

  int   n_checks = 0;
  int   n_pass = 0;
  run_t runs[$];
  int   fq[$];

  // engine models and monitor state
  int   exp_len = 10, ro_len = 10, exp_tmr = 0, ro_tmr = 0;
  int   n_trig = 0, n_rost = 0, ro_fin = 0, ro_base = 0;
  int   done_cnt = 0, hold_cycles = 0;
  bit   inj_pending = 0, seq_chk = 0;
  bit   s_valid = 0;
  logic s_hold = 0, s_busy = 0, s_start = 0, s_pend = 0, pend_m = 0;
  logic [ROW_W-1:0] s_rexp = '0, s_rro = '0;
  logic [CNT_W-1:0] fc_prev = '0, snap_fc = '0;
  int   snap_trig = 0, snap_rost = 0;
  logic snap_ovr = 0, snap_busy = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // One clock: observe outputs at the falling edge, then advance the engine models.
  task automatic tick();
    @(negedge CLK);
    if (!rst_n) begin
      exp_tmr = 0; ro_tmr = 0; exp_done_i = 1'b0; ro_busy_i = 1'b0;
      s_valid = 0; pend_m = 1'b0; fq.delete(); fc_prev = '0; inj_pending = 0;
      return;
    end
    if (s_valid) begin
      check_eq("rowadd", ROWADD, s_hold ? s_rro : s_rexp);
      check_eq("exp_hold", exp_hold_o, s_busy | s_pend);
      pend_m = s_start ? 1'b1 : (s_busy ? 1'b0 : s_pend);
    end
    if (exp_trigger_o || ro_start_o) check_eq("pulse_while_busy", busy, 1);
    if (ro_start_o) check_eq("rost_vs_ro_busy", ro_busy_i, 0);
    if (exp_trigger_o && seq_chk) check_eq("seq_trig_vs_ro_busy", ro_busy_i, 0);
    if (frame_cnt != fc_prev && frame_cnt != '0) begin
      if (fq.size() == 0) check_eq("frame_cnt_unexpected", frame_cnt, fc_prev);
      else check_eq("frame_cnt", frame_cnt, fq.pop_front());
    end
    fc_prev = frame_cnt;
    if (done) begin
      done_cnt++;
      snap_fc = frame_cnt; snap_trig = n_trig; snap_rost = n_rost;
      snap_ovr = ovr_err; snap_busy = busy;
    end
    if (dut.state_q == HOLD) hold_cycles++;
    // exposure engine
    exp_done_i = 1'b0;
    if (inj_pending) begin exp_done_i = 1'b1; inj_pending = 0; end
    if (exp_tmr > 0) begin
      exp_tmr--;
      if (exp_tmr == 0) exp_done_i = 1'b1;
    end
    if (exp_trigger_o) begin exp_tmr = exp_len; n_trig++; end
    // readout engine
    if (ro_tmr > 0) begin
      ro_tmr--;
      if (ro_tmr == 0) begin
        ro_busy_i = 1'b0; ro_fin++; fq.push_back(ro_fin - ro_base);
      end
    end
    if (ro_start_o) begin ro_tmr = ro_len; ro_busy_i = 1'b1; n_rost++; end
    rowadd_exp_i = ROW_W'($urandom);
    rowadd_ro_i  = ROW_W'($urandom);
    s_valid = 1; s_hold = exp_hold_o; s_busy = ro_busy_i; s_start = ro_start_o;
    s_pend = pend_m; s_rexp = rowadd_exp_i; s_rro = rowadd_ro_i;
  endtask

  task automatic start_run(int nf, bit ov, int el, int rl, int frames, bit ovr);
    tick();
    exp_len = el; ro_len = rl; num_frames = CNT_W'(nf); overlap_en = ov; start = 1'b1;
    ro_base = ro_fin;
    runs.push_back('{frames: frames, trig: n_trig + frames, rost: n_rost + frames, ovr: ovr});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget, bit lat_ro, bit lat_trig1);
    int   d0 = done_cnt;
    bit   prev_done = 0, first = 1, got = 0;
    run_t r;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (prev_done) begin
        if (lat_ro) check_eq({tag, "_rost_latency"}, ro_start_o, 1);
        if (lat_trig1 && first) begin
          check_eq({tag, "_trig_latency"}, exp_trigger_o, 1);
          first = 0;
        end
      end
      prev_done = exp_done_i;
      if (done_cnt != d0) begin got = 1; break; end
    end
    if (!got) begin
      check_eq({tag, "_done_timeout"}, done_cnt, d0 + 1);
      if (runs.size() > 0) void'(runs.pop_front());
      return;
    end
    r = runs.pop_front();
    check_eq({tag, "_frame_cnt"}, snap_fc, r.frames);
    check_eq({tag, "_exp_triggers"}, snap_trig, r.trig);
    check_eq({tag, "_ro_starts"}, snap_rost, r.rost);
    check_eq({tag, "_ovr_err"}, snap_ovr, r.ovr);
    check_eq({tag, "_idle_at_done"}, snap_busy, 0);
    repeat (30) tick();
    check_eq({tag, "_single_done"}, done_cnt, d0 + 1);
  endtask

  task automatic wait_state(string tag, state_t s, int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dut.state_q == s) return;
    end
    check_eq({tag, "_state_timeout"}, dut.state_q, s);
  endtask

  task automatic wait_frames(string tag, int n, int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (frame_cnt == CNT_W'(n)) return;
    end
    check_eq({tag, "_frames_timeout"}, frame_cnt, n);
  endtask

  initial begin
    int h0;
    rst_n = 1'b0;
    #1;
    check_eq("reset_outs", {exp_trigger_o, ro_start_o, exp_hold_o, busy, done, ovr_err,
                            ROWADD, frame_cnt}, 64'd0);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // 1: sequential, 3 frames
    seq_chk = 1;
    start_run(3, 0, 30, 40, 3, 0);
    wait_done("seq3", 2000, 0, 0);
    seq_chk = 0;

    // 2: overlap, long readout forces HOLD
    h0 = hold_cycles;
    start_run(4, 1, 200, 500, 4, 0);
    wait_done("ovl4", 5000, 0, 1);
    check_eq("ovl4_hold_seen", hold_cycles > h0, 1);

    // 3: exposure end aligned with readout end (fall, done-pulse, one after)
    for (int k = 0; k < 3; k++) begin
      start_run(3, 1, 60 + k, 60, 3, 0);
      wait_done("align", 2000, k != 0, 0);
    end

    // 4: free-run, stop after frame 5 with exposure 6 in flight
    seq_chk = 1;
    start_run(0, 0, 20, 30, 6, 0);
    wait_frames("freerun", 5, 2000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("freerun", 2000, 0, 0);
    seq_chk = 0;

    // 5: extra exposure result while one is parked
    start_run(3, 1, 50, 200, 3, 1);
    wait_state("inject", HOLD, 2000);
    inj_pending = 1;
    repeat (3) tick();
    check_eq("ovr_set", ovr_err, 1);
    wait_done("inject", 3000, 0, 0);
    repeat (20) tick();
    check_eq("ovr_sticky", ovr_err, 1);
    start_run(1, 0, 20, 30, 1, 0);
    check_eq("ovr_cleared_by_start", ovr_err, 0);
    wait_done("after_ovr", 1000, 0, 0);

    // 6: reset in READ_EXP
    start_run(3, 1, 50, 200, 3, 0);
    wait_frames("rst", 1, 2000);
    wait_state("rst", READ_EXP, 100);
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_mid_outs", {exp_trigger_o, ro_start_o, exp_hold_o, busy, done, ovr_err,
                                ROWADD, frame_cnt}, 64'd0);
    runs.delete();
    repeat (3) tick();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    start_run(2, 0, 20, 30, 2, 0);
    wait_done("post_rst", 1000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
